// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP controller with IR, IDCODE and BYPASS registers,
// plus select/strobe access to NUM_USER external user data registers.
module jtag_tap_core #(
   parameter int          IR_WIDTH = 4,
   parameter logic [31:0] IDCODE   = 32'h1234_5001,
   parameter int          NUM_USER = 2
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TMS,
   input  logic                TDI,
   output logic                TDO,
   output logic                Enable,
   input  logic [NUM_USER-1:0] UserTDO,
   output logic [NUM_USER-1:0] UserSel,
   output logic                CaptureDR,
   output logic                ShiftDR,
   output logic                UpdateDR,
   output logic                CaptureIR,
   output logic                ShiftIR,
   output logic                UpdateIR,
   output logic                Select,
   output logic                Reset,
   output logic [IR_WIDTH-1:0] Instr,
   output logic [3:0]          State
);

   typedef enum logic [3:0] {
      TLR      = 4'hF, RTI      = 4'hC,
      SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
      PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR = 4'h5,
      SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
      PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR = 4'hD
   } state_e;

   localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);

   state_e              state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;
   logic [31:0]         id_q, id_d;
   logic                byp_q, byp_d;
   logic                tdo_q, en_q;
   logic                src, user_tdo;

   always_ff @(posedge TCK) begin
      if (TRST) begin
         state_q <= TLR;
         ir_q    <= '0;
         instr_q <= OP_IDCODE;
         id_q    <= IDCODE;
         byp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         instr_q <= instr_d;
         id_q    <= id_d;
         byp_q   <= byp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:      state_d = TMS ? TLR      : RTI;
         RTI:      state_d = TMS ? SEL_DR   : RTI;
         SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
         SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
         CAP_DR:   state_d = TMS ? EX1_DR   : SH_DR;
         SH_DR:    state_d = TMS ? EX1_DR   : SH_DR;
         EX1_DR:   state_d = TMS ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_d = TMS ? EX2_DR   : PAUSE_DR;
         EX2_DR:   state_d = TMS ? UPD_DR   : SH_DR;
         UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
         CAP_IR:   state_d = TMS ? EX1_IR   : SH_IR;
         SH_IR:    state_d = TMS ? EX1_IR   : SH_IR;
         EX1_IR:   state_d = TMS ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_d = TMS ? EX2_IR   : PAUSE_IR;
         EX2_IR:   state_d = TMS ? UPD_IR   : SH_IR;
         UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
      endcase
   end

   always_comb begin
      ir_d    = ir_q;
      instr_d = instr_q;
      id_d    = id_q;
      byp_d   = byp_q;
      case (state_q)
         CAP_IR: ir_d = IR_WIDTH'(1);
         SH_IR:  ir_d = {TDI, ir_q[IR_WIDTH-1:1]};
         UPD_IR: instr_d = ir_q;
         CAP_DR: begin
            id_d  = IDCODE;
            byp_d = 1'b0;
         end
         SH_DR: begin
            id_d  = {TDI, id_q[31:1]};
            byp_d = TDI;
         end
         default: ;
      endcase
      // IDCODE is active on every edge in TLR and also on the edge entering it
      if (state_q == TLR || state_d == TLR)
         instr_d = OP_IDCODE;
   end

   always_comb begin
      UserSel = '0;
      for (int k = 0; k < NUM_USER; k++)
         UserSel[k] = (instr_q == IR_WIDTH'(k + 2));
   end

   assign user_tdo = |(UserSel & UserTDO);

   always_comb begin
      src = byp_q;
      if (state_q == SH_IR)
         src = ir_q[0];
      else if (instr_q == OP_IDCODE)
         src = id_q[0];
      else if (|UserSel)
         src = user_tdo;
   end

   always_ff @(negedge TCK) begin
      if (TRST) begin
         tdo_q <= 1'b0;
         en_q  <= 1'b0;
      end else if (state_q == SH_IR || state_q == SH_DR) begin
         tdo_q <= src;
         en_q  <= 1'b1;
      end else begin
         tdo_q <= 1'b0;
         en_q  <= 1'b0;
      end
   end

   assign TDO       = tdo_q;
   assign Enable    = en_q;
   assign CaptureDR = (state_q == CAP_DR);
   assign ShiftDR   = (state_q == SH_DR);
   assign UpdateDR  = (state_q == UPD_DR);
   assign CaptureIR = (state_q == CAP_IR);
   assign ShiftIR   = (state_q == SH_IR);
   assign UpdateIR  = (state_q == UPD_IR);
   assign Select    = state_q inside {SEL_IR, CAP_IR, SH_IR, EX1_IR,
                                      PAUSE_IR, EX2_IR, UPD_IR};
   assign Reset     = (state_q == TLR);
   assign Instr     = instr_q;
   assign State     = state_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: queue-based TAP model checked every cycle,
// plus directed scans with hand-computed expectations.
module tb_jtag_tap_core;
   localparam int          IRW = 4;
   localparam int          NU  = 2;
   localparam logic [31:0] IDC = 32'h1234_5001;

   logic           TCK  = 1'b0;
   logic           TRST = 1'b1;
   logic           TMS  = 1'b1;
   logic           TDI  = 1'b0;
   logic [NU-1:0]  UserTDO = '0;
   logic           TDO, Enable;
   logic [NU-1:0]  UserSel;
   logic           CaptureDR, ShiftDR, UpdateDR;
   logic           CaptureIR, ShiftIR, UpdateIR;
   logic           Select, Reset;
   logic [IRW-1:0] Instr;
   logic [3:0]     State;

   jtag_tap_core #(
      .IR_WIDTH(IRW), .IDCODE(IDC), .NUM_USER(NU)
   ) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
      .TDO(TDO), .Enable(Enable),
      .UserTDO(UserTDO), .UserSel(UserSel),
      .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
      .CaptureIR(CaptureIR), .ShiftIR(ShiftIR), .UpdateIR(UpdateIR),
      .Select(Select), .Reset(Reset), .Instr(Instr), .State(State)
   );

   always #5 TCK = ~TCK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // TAP graph as next-state tables indexed by state code
   logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

   logic [3:0] m_state;
   int         m_instr;
   bit         irq[$];
   bit         idq[$];
   bit         m_byp;
   bit         armed = 0;

   function automatic int ir_val();
      int v = 0;
      foreach (irq[i]) if (irq[i]) v += (1 << i);
      return v;
   endfunction

   task automatic load_id();
      logic [31:0] c;
      c = IDC;
      idq = {};
      for (int i = 0; i < 32; i++) idq.push_back(c[i]);
   endtask

   initial forever begin
      logic [3:0] s, ns;
      @(posedge TCK);
      if (TRST) begin
         armed   = 1;
         m_state = 4'hF;
         m_instr = 1;
         irq     = {};
         repeat (IRW) irq.push_back(1'b0);
         load_id();
         m_byp   = 1'b0;
      end else if (armed) begin
         s  = m_state;
         ns = TMS ? nxt1[s] : nxt0[s];
         case (s)
            4'hE: begin
               irq = {};
               irq.push_back(1'b1);
               repeat (IRW - 1) irq.push_back(1'b0);
            end
            4'hA: begin
               void'(irq.pop_front());
               irq.push_back(TDI);
            end
            4'hD: m_instr = ir_val();
            4'h6: begin
               load_id();
               m_byp = 1'b0;
            end
            4'h2: begin
               void'(idq.pop_front());
               idq.push_back(TDI);
               m_byp = TDI;
            end
            default: ;
         endcase
         if (s == 4'hF || ns == 4'hF) m_instr = 1;
         m_state = ns;
      end
   end

   initial forever begin
      logic          e_tdo, e_en, src;
      logic [7:0]    e_str, a_str;
      logic [NU-1:0] e_sel;
      @(negedge TCK);
      if (armed) begin
         if (m_instr == 1)
            src = idq[0];
         else if (m_instr >= 2 && m_instr < 2 + NU)
            src = UserTDO[m_instr-2];
         else
            src = m_byp;
         e_tdo = 1'b0;
         e_en  = 1'b0;
         if (!TRST && m_state == 4'hA) begin
            e_tdo = irq[0];
            e_en  = 1'b1;
         end else if (!TRST && m_state == 4'h2) begin
            e_tdo = src;
            e_en  = 1'b1;
         end
         for (int k = 0; k < NU; k++) e_sel[k] = (m_instr == k + 2);
         e_str = {m_state == 4'h6, m_state == 4'h2, m_state == 4'h5,
                  m_state == 4'hE, m_state == 4'hA, m_state == 4'hD,
                  m_state inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD},
                  m_state == 4'hF};
         #1;
         a_str = {CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR,
                  UpdateIR, Select, Reset};
         check("state", State, m_state);
         check("strobes", a_str, e_str);
         check("instr", Instr, m_instr);
         check("usersel", UserSel, e_sel);
         check("tdo", TDO, e_tdo);
         check("enable", Enable, e_en);
      end
   end

   task automatic step(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #2;
   endtask

   task automatic ir_scan(input logic [IRW-1:0] code,
                          output logic [IRW-1:0] o);
      o = '0;
      step(1, 0);
      step(1, 0);
      step(0, 0);
      for (int i = 0; i < IRW; i++) begin
         step(0, i == 0 ? 1'b0 : code[i-1]);
         o[i] = TDO;
      end
      step(1, code[IRW-1]);
      step(1, 0);
      step(0, 0);
   endtask

   task automatic dr_scan(input int n, input logic [31:0] t,
                          input logic [31:0] u, output logic [31:0] o);
      o = '0;
      step(1, 0);
      step(0, 0);
      for (int i = 0; i < n; i++) begin
         UserTDO = {~u[i], u[i]};
         step(0, i == 0 ? 1'b0 : t[i-1]);
         o[i] = TDO;
      end
      step(1, t[n-1]);
      step(1, 0);
      step(0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [IRW-1:0] r;
      logic [31:0]    o;

      step(1, 0);
      check("rst_state", State, 4'hF);
      check("rst_reset", Reset, 1'b1);
      check("rst_instr", Instr, 4'h1);
      check("rst_enable", Enable, 1'b0);
      TRST = 1'b0;
      step(0, 0);
      check("rti_state", State, 4'hC);
      check("rti_reset", Reset, 1'b0);

      dr_scan(32, 32'h0, 32'h0, o);
      check("idcode_read", o, 32'h1234_5001);

      ir_scan(4'b0010, r);
      check("ir_capture", r, 4'b0001);
      check("user0_instr", Instr, 4'h2);
      check("user0_sel", UserSel, 2'b01);
      dr_scan(4, 32'h0, 32'hD, o);
      check("user0_tdo", o, 32'hD);

      ir_scan(4'b0011, r);
      check("user1_sel", UserSel, 2'b10);
      dr_scan(4, 32'h0, 32'hD, o);
      check("user1_tdo", o, 32'h2);

      ir_scan(4'b1111, r);
      check("bypass_instr", Instr, 4'hF);
      dr_scan(4, 32'hD, 32'hF, o);
      check("bypass_tdo", o, 32'hA);

      ir_scan(4'b0111, r);
      check("unk_instr", Instr, 4'h7);
      check("unk_sel", UserSel, 2'b00);
      dr_scan(4, 32'hD, 32'hF, o);
      check("unk_tdo", o, 32'hA);

      ir_scan(4'b0100, r);
      check("nouser_sel", UserSel, 2'b00);
      dr_scan(4, 32'hD, 32'hF, o);
      check("nouser_tdo", o, 32'hA);

      ir_scan(4'b0010, r);
      step(1, 0);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      check("in_shir", State, 4'hA);
      repeat (5) step(1, 0);
      check("tms5_state", State, 4'hF);
      check("tms5_instr", Instr, 4'h1);
      step(0, 0);

      ir_scan(4'b0010, r);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      step(0, 1);
      step(0, 1);
      check("in_shdr_en", Enable, 1'b1);
      TRST = 1'b1;
      step(0, 0);
      check("trst_state", State, 4'hF);
      check("trst_enable", Enable, 1'b0);
      check("trst_upddr", UpdateDR, 1'b0);
      check("trst_instr", Instr, 4'h1);
      TRST = 1'b0;
      step(0, 0);
      check("post_state", State, 4'hC);
      repeat (3) step(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
